// File: rtl/vliw_imem_loader.sv
// Instruction-memory loader: packs a host byte stream into 48-bit VLIW bundles,
// writes them at successive word addresses, verifies a trailing XOR checksum.
module vliw_imem_loader #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned MAX_WORDS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [47:0]       im_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [3:0]        words_loaded
);

  localparam int unsigned BUNDLE_W = 48;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned WORD_W   = 4;
  localparam int unsigned LAST_IDX = 5;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t              state;
  state_t              nextState;
  logic [BUNDLE_W-1:0] bundle;
  logic [BUNDLE_W-1:0] bundleShifted;
  logic [BYTE_W-1:0]   checksum;
  logic [CNT_W-1:0]    byteCnt;
  logic [WORD_W-1:0]   numWords;
  logic [WORD_W-1:0]   wordsNext;
  logic                accept;
  logic                lastByte;
  logic                countBad;

  assign accept        = in_valid & in_ready;
  assign lastByte      = (byteCnt == CNT_W'(LAST_IDX));
  assign countBad      = (in_data == '0) || (in_data > BYTE_W'(MAX_WORDS));
  assign wordsNext     = words_loaded + WORD_W'(1);
  assign bundleShifted = {bundle[BUNDLE_W-BYTE_W-1:0], in_data};

  // Next-state decode; start is only honoured between loads.
  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE, ERROR: if (start) nextState = COUNT;
      COUNT:             if (accept) nextState = countBad ? ERROR : DATA;
      DATA:              if (accept && lastByte) nextState = WRITE;
      WRITE:             nextState = (wordsNext == numWords) ? CHECK : DATA;
      CHECK:             if (accept) nextState = (in_data == checksum) ? DONE : ERROR;
      default:           nextState = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      core_hold    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      bundle       <= '0;
      checksum     <= '0;
      byteCnt      <= '0;
      numWords     <= '0;
    end else begin
      state     <= nextState;
      in_ready  <= (nextState inside {COUNT, DATA, CHECK});
      im_we     <= (nextState == WRITE);
      core_hold <= (nextState != DONE);
      done      <= (nextState == DONE);
      error     <= (nextState == ERROR);
      case (state)
        COUNT: begin
          if (accept && !countBad) begin
            numWords     <= in_data[WORD_W-1:0];
            words_loaded <= '0;
            checksum     <= '0;
            byteCnt      <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            bundle   <= bundleShifted;
            checksum <= checksum ^ in_data;
            byteCnt  <= lastByte ? '0 : byteCnt + CNT_W'(1);
            // Address/data are presented with the strobe and then held.
            if (lastByte) begin
              im_addr  <= ADDR_W'({words_loaded, 2'b00});
              im_wdata <= bundleShifted;
            end
          end
        end
        WRITE:   words_loaded <= wordsNext;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vliw_imem_loader.sv
// Randomized bench for vliw_imem_loader against a frame-level model of expected
// writes and final load status.
module tb_vliw_imem_loader;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned MAX_WORDS = 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [47:0]       im_wdata;
  logic              core_hold;
  logic              done;
  logic              error;
  logic [3:0]        words_loaded;

  vliw_imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .core_hold    (core_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;
  int cycle   = 0;
  int accCount = 0;
  int totalWrites = 0;
  int frameId = 0;
  bit streaming = 1'b0;
  int lastWeCycle = -1;
  int lastWeFrame = -1;
  logic [ADDR_W-1:0] lastAddr = '0;
  logic [47:0]       lastData = '0;
  logic [3:0]        modelWords = '0;
  logic [ADDR_W-1:0] expAddrQ[$];
  logic [47:0]       expDataQ[$];
  logic [7:0]        payload[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cycle <= cycle + 1;
  always @(posedge clk) if (reset && in_valid && in_ready) accCount <= accCount + 1;

  // Per-cycle compare: every write strobe must match the next expected bundle.
  always @(negedge clk) begin
    if (reset) begin
      chk("hold_vs_done", 64'(core_hold), 64'(!done));
      chk("done_err_excl", 64'(done & error), 64'(0));
      if (im_we) begin
        chk("we_ready_low", 64'(in_ready), 64'(0));
        totalWrites++;
        if (expAddrQ.size() == 0) begin
          nChecks++;
          $display("FAIL unexpected_write: addr=%0h data=%h", im_addr, im_wdata);
        end else begin
          chk("wr_addr", 64'(im_addr), 64'(expAddrQ.pop_front()));
          chk("wr_data", 64'(im_wdata), 64'(expDataQ.pop_front()));
        end
        if (streaming && lastWeFrame == frameId)
          chk("bundle_period", 64'(cycle - lastWeCycle), 64'(7));
        lastWeCycle = cycle;
        lastWeFrame = frameId;
        lastAddr = im_addr;
        lastData = im_wdata;
      end
    end
  end

  function automatic logic [7:0] payloadXor(input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++) x ^= payload[i];
    return x;
  endfunction

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one byte, optionally after idle gaps, and hold it until accepted.
  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int budget = 50;
    bit rdy;
    if (gaps) begin
      int g = $urandom_range(0, 2);
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      budget--;
      if (budget == 0) begin
        nChecks++;
        $display("FAIL byte_timeout: byte %0h never accepted", b);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Drives one frame from the payload queue and checks the resulting load status.
  task automatic runFrame(input logic [7:0] cnt, input logic [7:0] chkByte,
                          input bit gaps, input bit midStart);
    bit badCount = (cnt == 8'd0) || (cnt > 8'(MAX_WORDS));
    bit expOk;
    int acc0;
    int wr0;
    int nPay = badCount ? 0 : 6 * int'(cnt);
    logic [47:0] w;
    frameId++;
    streaming = !gaps && !midStart;
    for (int i = 0; i < nPay / 6; i++) begin
      w = '0;
      for (int j = 0; j < 6; j++) w = {w[39:0], payload[6*i+j]};
      expAddrQ.push_back(ADDR_W'(4 * i));
      expDataQ.push_back(w);
    end
    expOk = !badCount && (chkByte == payloadXor(nPay));
    acc0 = accCount;
    wr0  = totalWrites;
    pulseStart();
    chk("start_ready", 64'(in_ready), 64'(1));
    chk("start_hold", 64'(core_hold), 64'(1));
    chk("start_done_clr", 64'(done), 64'(0));
    chk("start_err_clr", 64'(error), 64'(0));
    sendByte(cnt, gaps);
    if (!badCount) begin
      for (int k = 0; k < nPay; k++) begin
        if (midStart && k == 3) pulseStart();
        sendByte(payload[k], gaps);
      end
      sendByte(chkByte, gaps);
      modelWords = cnt[3:0];
    end
    chk("done", 64'(done), 64'(expOk));
    chk("error", 64'(error), 64'(!expOk));
    chk("core_hold", 64'(core_hold), 64'(!expOk));
    chk("words_loaded", 64'(words_loaded), 64'(modelWords));
    chk("bytes_accepted", 64'(accCount - acc0), 64'(badCount ? 1 : nPay + 2));
    chk("writes", 64'(totalWrites - wr0), 64'(nPay / 6));
    chk("writes_pending", 64'(expAddrQ.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("status_stable", 64'({done, error}), 64'({expOk, !expOk}));
    chk("ready_idle", 64'(in_ready), 64'(0));
  endtask

  task automatic setPayload(input logic [47:0] b0, input logic [47:0] b1, input int n);
    logic [47:0] t;
    payload.delete();
    for (int i = 0; i < n; i++) begin
      t = (i == 0) ? b0 : b1;
      for (int j = 5; j >= 0; j--) payload.push_back(t[8*j +: 8]);
    end
  endtask

  task automatic checkResetValues(input string tag);
    chk({tag, "_ready"}, 64'(in_ready), 64'(0));
    chk({tag, "_we"}, 64'(im_we), 64'(0));
    chk({tag, "_addr"}, 64'(im_addr), 64'(0));
    chk({tag, "_wdata"}, 64'(im_wdata), 64'(0));
    chk({tag, "_hold"}, 64'(core_hold), 64'(1));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_error"}, 64'(error), 64'(0));
    chk({tag, "_words"}, 64'(words_loaded), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("por");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ready", 64'(in_ready), 64'(0));

    // Single bundle; XOR of 12 34 56 78 9A BC is 2E.
    setPayload(48'h123456789ABC, 48'h0, 1);
    runFrame(8'd1, 8'h2E, 1'b0, 1'b0);
    chk("t2_addr", 64'(lastAddr), 64'(0));
    chk("t2_data", 64'(lastData), 64'h123456789ABC);
    chk("t2_done", 64'(done), 64'(1));

    // Reset mid-DATA aborts the load without further writes.
    setPayload(48'hA5A5A5A5A5A5, 48'h5A5A5A5A5A5A, 2);
    pulseStart();
    sendByte(8'd2, 1'b0);
    for (int k = 0; k < 3; k++) sendByte(payload[k], 1'b0);
    #3 reset = 1'b0;
    #1 checkResetValues("rst_async");
    @(posedge clk); #1;
    checkResetValues("rst_edge");
    reset = 1'b1;
    modelWords = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_hold", 64'(core_hold), 64'(1));

    // Two bundles with random host gaps.
    setPayload(48'h000000000001, 48'h000000000002, 2);
    runFrame(8'd2, 8'h03, 1'b1, 1'b0);
    chk("t3_addr", 64'(lastAddr), 64'(4));
    chk("t3_data", 64'(lastData), 64'h000000000002);

    // Bad checksum: bundle still written, load flagged.
    setPayload(48'h123456789ABC, 48'h0, 1);
    runFrame(8'd1, 8'h87, 1'b0, 1'b0);
    chk("t4_error", 64'(error), 64'(1));
    chk("t4_addr", 64'(lastAddr), 64'(0));

    // Illegal counts.
    runFrame(8'd0, 8'h00, 1'b0, 1'b0);
    runFrame(8'd9, 8'h00, 1'b0, 1'b0);
    chk("t5_error", 64'(error), 64'(1));

    // Start during DATA is ignored; next frame's start clears done.
    setPayload(48'hDEADBEEF0102, 48'hCAFEF00D0304, 2);
    runFrame(8'd2, payloadXor(12), 1'b0, 1'b1);
    setPayload(48'h0F0E0D0C0B0A, 48'h0, 1);
    runFrame(8'd1, payloadXor(6), 1'b0, 1'b0);

    // Randomized frames.
    repeat (10) begin
      logic [7:0] cnt;
      logic [7:0] cb;
      int n;
      if ($urandom_range(0, 7) == 0)
        cnt = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_WORDS + 1, 255));
      else
        cnt = 8'($urandom_range(1, MAX_WORDS));
      n = (cnt >= 8'd1 && cnt <= 8'(MAX_WORDS)) ? 6 * int'(cnt) : 0;
      payload.delete();
      for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
      cb = payloadXor(n);
      if ($urandom_range(0, 3) == 0) cb ^= 8'($urandom_range(1, 255));
      runFrame(cnt, cb, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
